uart_servo_cmd: RTL and testbench
=================================

Name: uart_servo_cmd

Overview:
- Command framer and decoder between uart_rx and servo_control.
- Consumes the byte stream from uart_rx (o_uart_rx_valid / o_uart_rx_data), assembles 4-byte frames (CMD, DATA_H, DATA_L, 0x0A) and validates them.
- Converts the command into a pulse width in clock cycles, driven straight into servo_control.in_pwm.
- Replaces the fixed width constant in the top level. Frame status and last command go to the control LEDs.

Parameters:
- PW_W, 20, width of pulse-width output in bits.
- PULSE_MIN, 27000, pulse width in cycles for angle 0 (1 ms at 27 MHz).
- PULSE_MAX, 54000, pulse width in cycles for angle 180 (2 ms); also the clamp ceiling.
- STEP, 150, cycles per degree; PULSE_MIN + 180*STEP must equal PULSE_MAX.
- TIMEOUT_CYCLES, 270000, maximum idle cycles between bytes of one frame (10 ms).
- TERM_BYTE, 8'h0A, frame terminator.

Ports:
- i_clk  in  1  system clock.
- i_resetn  in  1  asynchronous active-low reset.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid this cycle.
- i_rx_data  in  8  received byte.
- i_rx_break  in  1  line break from uart_rx; aborts the current frame.
- o_pwm_width  out  PW_W  pulse width in cycles, to servo_control.in_pwm.
- o_pwm_update  out  1  one-cycle pulse when o_pwm_width is reloaded.
- o_frame_err  out  1  one-cycle pulse on any rejected frame.
- o_err_count  out  8  saturating count of rejected frames.
- o_last_cmd  out  8  CMD byte of the last accepted frame.

Behaviour:
- Reset (asynchronous, i_resetn=0):
  - state=IDLE, o_pwm_width=(PULSE_MIN+PULSE_MAX)/2=40500.
  - o_pwm_update=0, o_frame_err=0, o_err_count=0, o_last_cmd=0.
  - Timeout counter=0, holding registers cleared.
- States: IDLE, GOT_CMD, GOT_HI, GOT_LO, EXEC.
  - IDLE: valid byte -> store CMD -> GOT_CMD.
  - GOT_CMD: valid byte -> DATA_H -> GOT_HI.
  - GOT_HI: valid byte -> DATA_L -> GOT_LO.
  - GOT_LO: valid byte == TERM_BYTE -> EXEC. Any other byte -> reject -> IDLE (byte discarded, not reused as CMD).
  - EXEC: lasts one cycle, then -> IDLE. A valid byte in EXEC is taken as the CMD of the next frame (-> GOT_CMD).
- Decode in EXEC, with V = {DATA_H, DATA_L}:
  - CMD 0x00: centre, width=(PULSE_MIN+PULSE_MAX)/2.
  - CMD 0x01: angle; V<=180 -> width=PULSE_MIN+V*STEP; V>180 -> reject.
  - CMD 0x02: raw width; clamp V to [PULSE_MIN, PULSE_MAX].
  - Any other CMD: reject.
- Arithmetic: V*STEP computed at PW_W+8 bits; no truncation before the clamp or range check.
- Latency:
  - o_pwm_width and o_pwm_update=1 appear on the second rising edge after the edge that samples the terminator (registered EXEC result).
  - o_last_cmd updates on that same edge.
  - o_pwm_width holds its value between updates and on any reject.
- Reject:
  - o_frame_err pulses for one cycle, one cycle after the reject decision.
  - o_err_count increments and saturates at 255.
  - o_pwm_width is unchanged.
- Timeout:
  - Counter clears on every valid byte and runs in GOT_CMD, GOT_HI and GOT_LO.
  - Reaching TIMEOUT_CYCLES -> reject -> IDLE.
  - No timeout in IDLE.
- Break:
  - i_rx_break=1 in any non-IDLE state -> reject -> IDLE.
  - Break in IDLE: no error.
  - Break and i_rx_valid in the same cycle: break wins, the byte is dropped.
- Reset mid-frame: immediate return to reset values; the partial frame is lost.
- A 0x0A byte in IDLE, GOT_CMD or GOT_HI is ordinary data, not a terminator.

Test Plan:
- Reset only -> o_pwm_width=40500, o_err_count=0, o_pwm_update never pulses.
- Frame 01 00 5A 0A (angle 90) -> o_pwm_width=40500, o_pwm_update one cycle 2 edges after the 0A, o_last_cmd=0x01. Then frame 01 00 B4 0A -> 54000. Then frame 01 00 00 0A -> 27000.
- Frame 02 FF FF 0A -> o_pwm_width=54000 (clamped). Frame 02 00 10 0A -> 27000. Frame 01 00 B5 0A (181) -> rejected, width unchanged, o_err_count=1.
- Frame 01 00 5A 0B -> o_frame_err pulse, count+1. The next valid frame 00 00 00 0A is accepted -> 40500.
- Send 01 00, then idle 270000 cycles -> reject at timeout. Late bytes 5A 0A are then parsed as a new CMD and DATA_H, no update.
- Break asserted after 01 5A -> reject. Break in IDLE -> no error. 300 bad frames -> o_err_count stays 255.

Source files
------------

// File: rtl/uart_servo_cmd.sv
// rtl/uart_servo_cmd.sv - UART command framer/decoder producing a servo pulse width
//
// Assembles 4-byte frames (CMD, DATA_H, DATA_L, TERM_BYTE) from the uart_rx
// byte strobe, validates and decodes them into a pulse width in clock cycles.
//
// Ports:
//   i_clk, i_resetn      clock, asynchronous active-low reset
//   i_rx_valid/i_rx_data received byte strobe and data
//   i_rx_break           line break, aborts a frame in progress
//   o_pwm_width          pulse width in cycles (to servo_control.in_pwm)
//   o_pwm_update         one-cycle pulse when o_pwm_width is reloaded
//   o_frame_err          one-cycle pulse per rejected frame
//   o_err_count          saturating rejected-frame count
//   o_last_cmd           CMD byte of the last accepted frame
module uart_servo_cmd #(
  parameter int         PW_W           = 20,
  parameter int         PULSE_MIN      = 27000,
  parameter int         PULSE_MAX      = 54000,
  parameter int         STEP           = 150,
  parameter int         TIMEOUT_CYCLES = 270000,
  parameter logic [7:0] TERM_BYTE      = 8'h0A
) (
  input  logic            i_clk,
  input  logic            i_resetn,
  input  logic            i_rx_valid,
  input  logic [7:0]      i_rx_data,
  input  logic            i_rx_break,
  output logic [PW_W-1:0] o_pwm_width,
  output logic            o_pwm_update,
  output logic            o_frame_err,
  output logic [7:0]      o_err_count,
  output logic [7:0]      o_last_cmd
);

  // Decode arithmetic runs 8 bits wider than the output so the angle product
  // and raw value are never truncated before the range check / clamp.
  localparam int             XW      = PW_W + 8;
  localparam logic [XW-1:0]  MIN_X   = XW'(PULSE_MIN);
  localparam logic [XW-1:0]  MAX_X   = XW'(PULSE_MAX);
  localparam logic [XW-1:0]  STEP_X  = XW'(STEP);
  localparam logic [PW_W-1:0] CENTER = PW_W'((PULSE_MIN + PULSE_MAX) / 2);
  localparam int             TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GOT_CMD,
    S_GOT_HI,
    S_GOT_LO,
    S_EXEC
  } state_t;

  state_t state, state_next;

  logic [7:0]      cmd_q, hi_q, lo_q;
  logic [TO_W-1:0] to_cnt;
  logic            in_frame;
  logic            timeout_hit;

  logic            ld_cmd, ld_hi, ld_lo;
  logic            reject;
  logic            exec_ok;

  logic            dec_ok;
  logic [PW_W-1:0] dec_width;
  logic [15:0]     v;
  logic [XW-1:0]   v_x;

  // Registered EXEC result; outputs load from here one edge later.
  logic            res_valid;
  logic [PW_W-1:0] res_width;
  logic [7:0]      res_cmd;

  assign in_frame    = (state == S_GOT_CMD) || (state == S_GOT_HI) || (state == S_GOT_LO);
  assign timeout_hit = (to_cnt == TO_LAST);
  assign v           = {hi_q, lo_q};
  assign v_x         = XW'(v);

  // Frame decode from the holding registers.
  always_comb begin
    dec_ok    = 1'b0;
    dec_width = CENTER;
    case (cmd_q)
      8'h00: dec_ok = 1'b1;
      8'h01: begin
        if (v <= 16'd180) begin
          dec_ok    = 1'b1;
          dec_width = PW_W'(MIN_X + v_x * STEP_X);
        end
      end
      8'h02: begin
        dec_ok = 1'b1;
        if (v_x < MIN_X)      dec_width = PW_W'(MIN_X);
        else if (v_x > MAX_X) dec_width = PW_W'(MAX_X);
        else                  dec_width = PW_W'(v_x);
      end
      default: dec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) state <= S_IDLE;
    else           state <= state_next;
  end

  // Break always wins over a byte arriving in the same cycle; a pending
  // valid byte suppresses the timeout for that cycle.
  always_comb begin
    state_next = state;
    ld_cmd     = 1'b0;
    ld_hi      = 1'b0;
    ld_lo      = 1'b0;
    reject     = 1'b0;
    exec_ok    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!i_rx_break && i_rx_valid) begin
          ld_cmd     = 1'b1;
          state_next = S_GOT_CMD;
        end
      end
      S_GOT_CMD: begin
        if (i_rx_break) begin
          reject     = 1'b1;
          state_next = S_IDLE;
        end else if (i_rx_valid) begin
          ld_hi      = 1'b1;
          state_next = S_GOT_HI;
        end else if (timeout_hit) begin
          reject     = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_GOT_HI: begin
        if (i_rx_break) begin
          reject     = 1'b1;
          state_next = S_IDLE;
        end else if (i_rx_valid) begin
          ld_lo      = 1'b1;
          state_next = S_GOT_LO;
        end else if (timeout_hit) begin
          reject     = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_GOT_LO: begin
        if (i_rx_break) begin
          reject     = 1'b1;
          state_next = S_IDLE;
        end else if (i_rx_valid) begin
          // A wrong terminator is discarded, not reused as the next CMD.
          if (i_rx_data == TERM_BYTE) begin
            state_next = S_EXEC;
          end else begin
            reject     = 1'b1;
            state_next = S_IDLE;
          end
        end else if (timeout_hit) begin
          reject     = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_EXEC: begin
        if (i_rx_break) begin
          reject     = 1'b1;
          state_next = S_IDLE;
        end else begin
          exec_ok = dec_ok;
          reject  = !dec_ok;
          if (i_rx_valid) begin
            ld_cmd     = 1'b1;
            state_next = S_GOT_CMD;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      cmd_q  <= 8'h00;
      hi_q   <= 8'h00;
      lo_q   <= 8'h00;
      to_cnt <= '0;
    end else begin
      if (ld_cmd) cmd_q <= i_rx_data;
      if (ld_hi)  hi_q  <= i_rx_data;
      if (ld_lo)  lo_q  <= i_rx_data;
      if (in_frame && !i_rx_valid) to_cnt <= to_cnt + TO_W'(1);
      else                         to_cnt <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      res_valid    <= 1'b0;
      res_width    <= CENTER;
      res_cmd      <= 8'h00;
      o_pwm_width  <= CENTER;
      o_pwm_update <= 1'b0;
      o_last_cmd   <= 8'h00;
      o_frame_err  <= 1'b0;
      o_err_count  <= 8'h00;
    end else begin
      res_valid <= exec_ok;
      if (exec_ok) begin
        res_width <= dec_width;
        res_cmd   <= cmd_q;
      end
      o_pwm_update <= res_valid;
      if (res_valid) begin
        o_pwm_width <= res_width;
        o_last_cmd  <= res_cmd;
      end
      o_frame_err <= reject;
      if (reject && (o_err_count != 8'hFF)) o_err_count <= o_err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_servo_cmd.sv
// tb/tb_uart_servo_cmd.sv - self-checking bench for uart_servo_cmd
module tb_uart_servo_cmd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_break;
  logic [19:0] pwm_width;
  logic        pwm_update;
  logic        frame_err;
  logic [7:0]  err_count;
  logic [7:0]  last_cmd;

  always #5 clk = ~clk;

  uart_servo_cmd #(.TIMEOUT_CYCLES(200)) dut (
    .i_clk       (clk),
    .i_resetn    (rst_n),
    .i_rx_valid  (rx_valid),
    .i_rx_data   (rx_data),
    .i_rx_break  (rx_break),
    .o_pwm_width (pwm_width),
    .o_pwm_update(pwm_update),
    .o_frame_err (frame_err),
    .o_err_count (err_count),
    .o_last_cmd  (last_cmd)
  );

  typedef struct {
    logic [7:0] b0, b1, b2, b3;
    bit         acc;
    int         width;
  } vec_t;

  typedef struct {
    bit         is_err;
    int         width;
    logic [7:0] cmd;
  } exp_t;

  exp_t sbq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int model_width = 40500;
  int model_err   = 0;
  int model_last  = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: every update / error pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (pwm_update) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_unexpected_update: got width %0d with empty queue", pwm_width);
        end else begin
          e = sbq.pop_front();
          check("sb_kind_update", 0, e.is_err);
          check("sb_width", pwm_width, e.width);
          check("sb_last_cmd", last_cmd, e.cmd);
        end
      end
      if (frame_err) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_unexpected_err: got frame_err with empty queue");
        end else begin
          e = sbq.pop_front();
          check("sb_kind_err", 1, e.is_err);
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1; e.width = 0; e.cmd = 8'h00;
    sbq.push_back(e);
    if (model_err < 255) model_err++;
  endtask

  task automatic expect_upd(input int w, input logic [7:0] c);
    exp_t e;
    e.is_err = 1'b0; e.width = w; e.cmd = c;
    sbq.push_back(e);
    model_width = w;
    model_last  = c;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_width"}, pwm_width, model_width);
    check({tag, "_err_count"}, err_count, model_err);
    check({tag, "_last_cmd"}, last_cmd, model_last);
  endtask

  task automatic run_frame(input logic [7:0] b0, b1, b2, b3, input bit acc, input int w);
    if (acc) expect_upd(w, b0);
    else     expect_err();
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    send_byte(b3);
    wait_cycles(4);
  endtask

  task automatic pulse_break();
    @(posedge clk); #1;
    rx_break = 1'b1;
    @(posedge clk); #1;
    rx_break = 1'b0;
  endtask

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{8'h01, 8'h00, 8'h5A, 8'h0A, 1'b1, 40500};
    vecs[1]  = '{8'h01, 8'h00, 8'hB4, 8'h0A, 1'b1, 54000};
    vecs[2]  = '{8'h01, 8'h00, 8'h00, 8'h0A, 1'b1, 27000};
    vecs[3]  = '{8'h02, 8'hFF, 8'hFF, 8'h0A, 1'b1, 54000};
    vecs[4]  = '{8'h02, 8'h00, 8'h10, 8'h0A, 1'b1, 27000};
    vecs[5]  = '{8'h01, 8'h00, 8'hB5, 8'h0A, 1'b0, 0};
    vecs[6]  = '{8'h01, 8'h00, 8'h5A, 8'h0B, 1'b0, 0};
    vecs[7]  = '{8'h00, 8'h00, 8'h00, 8'h0A, 1'b1, 40500};
    vecs[8]  = '{8'h02, 8'h9C, 8'h40, 8'h0A, 1'b1, 40000};
    vecs[9]  = '{8'h01, 8'h00, 8'h2D, 8'h0A, 1'b1, 33750};
    vecs[10] = '{8'h05, 8'h00, 8'h00, 8'h0A, 1'b0, 0};
    vecs[11] = '{8'h02, 8'hD2, 8'hF0, 8'h0A, 1'b1, 54000};
    vecs[12] = '{8'h02, 8'h69, 8'h78, 8'h0A, 1'b1, 27000};
    vecs[13] = '{8'h02, 8'h69, 8'h77, 8'h0A, 1'b1, 27000};
    vecs[14] = '{8'h01, 8'h01, 8'h00, 8'h0A, 1'b0, 0};
    vecs[15] = '{8'h02, 8'h0A, 8'h0A, 8'h0A, 1'b1, 27000};
    vecs[16] = '{8'h0A, 8'h00, 8'h00, 8'h0A, 1'b0, 0};

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rx_break = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;

    // Reset state, then idle: no pulses allowed.
    check("reset_update", pwm_update, 0);
    check("reset_frame_err", frame_err, 0);
    check_state("reset");
    wait_cycles(20);
    check_state("idle");

    for (int i = 0; i < 17; i++) begin
      run_frame(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3, vecs[i].acc, vecs[i].width);
      check_state($sformatf("vec%0d", i));
    end

    // Update latency: pulse on the second edge after the terminator edge.
    expect_upd(36000, 8'h01);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h3C);
    send_byte(8'h0A);
    @(negedge clk); check("lat_edge0", pwm_update, 0);
    @(negedge clk); check("lat_edge1", pwm_update, 0);
    @(negedge clk); check("lat_edge2", pwm_update, 1);
    check("lat_width", pwm_width, 36000);
    @(negedge clk); check("lat_edge3", pwm_update, 0);
    wait_cycles(2);
    check_state("latency");

    // Timeout after 01 00, then late 5A 0A start a fresh frame that times out too.
    send_byte(8'h01);
    send_byte(8'h00);
    wait_cycles(150);
    check_state("timeout_pre");
    expect_err();
    wait_cycles(100);
    check_state("timeout_hit");
    send_byte(8'h5A);
    send_byte(8'h0A);
    expect_err();
    wait_cycles(250);
    check_state("timeout_late");

    // Break mid-frame rejects.
    send_byte(8'h01);
    send_byte(8'h5A);
    expect_err();
    pulse_break();
    wait_cycles(3);
    check_state("break_frame");

    // Break in IDLE is harmless.
    pulse_break();
    wait_cycles(3);
    check_state("break_idle");

    // Break with a byte in the same cycle: byte dropped, next frame clean.
    @(posedge clk); #1;
    rx_break = 1'b1; rx_valid = 1'b1; rx_data = 8'h01;
    @(posedge clk); #1;
    rx_break = 1'b0; rx_valid = 1'b0;
    run_frame(8'h02, 8'h9C, 8'h40, 8'h0A, 1'b1, 40000);
    check_state("break_valid");

    // Reset mid-frame drops the partial frame and restores reset values.
    send_byte(8'h02);
    send_byte(8'h9C);
    rst_n = 1'b0;
    #2;
    model_width = 40500; model_err = 0; model_last = 0;
    check_state("midreset");
    wait_cycles(2);
    rst_n = 1'b1;
    run_frame(8'h01, 8'h00, 8'h5A, 8'h0A, 1'b1, 40500);
    check_state("after_reset");

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) begin
      run_frame(8'h01, 8'h00, 8'h00, 8'h0B, 1'b0, 0);
    end
    check_state("saturate");
    check("sat_255", err_count, 255);

    wait_cycles(5);
    check("sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
